arbitro_memoria_dados: RTL and testbench

//  Shares the 256x8 data memory between two requesters: A = nRISC core load/store, B = loader/debug port.
//  Two-way arbiter with req/ack handshake. Latches each winning request and drives the memory's MemWrite/MemRead/address/data pins.

---
 rtl/nrisc_mem_pkg.sv | 8 +
 rtl/arbitro_rr2.sv | 35 +++
 rtl/arbitro_memoria_dados.sv | 84 ++++++++
 tb/tb_arbitro_memoria_dados.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_mem_pkg.sv
// nrisc_mem_pkg: shared constants and state encoding for the data-memory arbiter
package nrisc_mem_pkg;
  localparam int LARGURA_END = 8;
  localparam int LARGURA_DADO = 8;
  localparam int REQ_A = 0;
  localparam int REQ_B = 1;
  typedef enum logic [1:0] {OCIOSO = 2'd0, SERV_A = 2'd1, SERV_B = 2'd2} estado_t;
endpackage

// File: rtl/arbitro_rr2.sv
// arbitro_rr2: two-way grant logic with round-robin pointer and fixed-priority anti-starvation counter
//  clk, reset   clock, asynchronous active-low reset
//  req_i[1:0]   masked requests (bit REQ_A, bit REQ_B)
//  avanca_i     an arbitration is taken at this edge (pointer/counter may move)
//  gnt_o[1:0]   one-hot grant, combinational
module arbitro_rr2 #(
  parameter int PRIORIDADE_A = 0,
  parameter int MAX_ESPERA = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       avanca_i,
  output logic [1:0] gnt_o
);
  import nrisc_mem_pkg::*;
  logic ptr_q;
  logic [3:0] espera_q;
  logic ambos, vence_b;
  always_comb begin
    ambos = &req_i;
    vence_b = ambos ? ((PRIORIDADE_A != 0) ? (espera_q == 4'(MAX_ESPERA)) : ptr_q) : req_i[REQ_B];
    gnt_o = {vence_b, ~vence_b} & req_i;
  end
  // Pointer moves only on a real contest; counter counts contests B lost and clears whenever B wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
      espera_q <= '0;
    end else if (avanca_i) begin
      if (ambos) ptr_q <= ~vence_b;
      espera_q <= (vence_b || PRIORIDADE_A == 0) ? '0 : espera_q + 4'(ambos);
    end
  end
endmodule

// File: rtl/arbitro_memoria_dados.sv
// arbitro_memoria_dados: shares the data memory between the core (A) and the loader/debug port (B)
//  clk, reset              clock, asynchronous active-low reset
//  req/esc/end/dado_{a,b}  request, write flag, address, write data (sampled at grant)
//  ack_{a,b}               one-cycle completion pulse
//  leitura_{a,b}           last read data of each requester
//  ocupado                 an access is in service
//  mem_*                   memory MemWrite/MemRead/address/write data; mem_dado_saida is the read data
module arbitro_memoria_dados #(
  parameter int LARGURA_END = nrisc_mem_pkg::LARGURA_END,
  parameter int LARGURA_DADO = nrisc_mem_pkg::LARGURA_DADO,
  parameter int PRIORIDADE_A = 0,
  parameter int MAX_ESPERA = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_a,
  input  logic                    req_b,
  input  logic                    esc_a,
  input  logic                    esc_b,
  input  logic [LARGURA_END-1:0]  end_a,
  input  logic [LARGURA_END-1:0]  end_b,
  input  logic [LARGURA_DADO-1:0] dado_a,
  input  logic [LARGURA_DADO-1:0] dado_b,
  output logic                    ack_a,
  output logic                    ack_b,
  output logic [LARGURA_DADO-1:0] leitura_a,
  output logic [LARGURA_DADO-1:0] leitura_b,
  output logic                    ocupado,
  output logic                    mem_habilita_escrita,
  output logic                    mem_habilita_leitura,
  output logic [LARGURA_END-1:0]  mem_endereco,
  output logic [LARGURA_DADO-1:0] mem_dado_entrada,
  input  logic [LARGURA_DADO-1:0] mem_dado_saida
);
  import nrisc_mem_pkg::*;
  estado_t estado_q, estado_d;
  logic esc_q, ack_a_q, ack_b_q;
  logic [LARGURA_END-1:0] end_q;
  logic [LARGURA_DADO-1:0] dado_q, leitura_a_q, leitura_b_q;
  logic [1:0] req_m, gnt;
  // The request being served is still high at its closing edge, so it is masked to avoid serving it twice.
  assign req_m = {req_b & (estado_q != SERV_B), req_a & (estado_q != SERV_A)};
  arbitro_rr2 #(.PRIORIDADE_A(PRIORIDADE_A), .MAX_ESPERA(MAX_ESPERA)) u_arb (
    .clk(clk),
    .reset(reset),
    .req_i(req_m),
    .avanca_i(|req_m),
    .gnt_o(gnt)
  );
  always_comb estado_d = gnt[REQ_A] ? SERV_A : gnt[REQ_B] ? SERV_B : OCIOSO;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      esc_q <= 1'b0;
      end_q <= '0;
      dado_q <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      leitura_a_q <= '0;
      leitura_b_q <= '0;
    end else begin
      estado_q <= estado_d;
      ack_a_q <= estado_q == SERV_A;
      ack_b_q <= estado_q == SERV_B;
      if (estado_q == SERV_A && !esc_q) leitura_a_q <= mem_dado_saida;
      if (estado_q == SERV_B && !esc_q) leitura_b_q <= mem_dado_saida;
      if (|gnt) begin
        esc_q <= gnt[REQ_A] ? esc_a : esc_b;
        end_q <= gnt[REQ_A] ? end_a : end_b;
        dado_q <= gnt[REQ_A] ? dado_a : dado_b;
      end
    end
  end
  // Pins come straight from registers: enables fall with the async reset and address/data hold when idle.
  assign ocupado = estado_q != OCIOSO;
  assign mem_habilita_escrita = ocupado & esc_q;
  assign mem_habilita_leitura = ocupado & ~esc_q;
  assign mem_endereco = end_q;
  assign mem_dado_entrada = dado_q;
  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign leitura_a = leitura_a_q;
  assign leitura_b = leitura_b_q;
endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// tb_arbitro_memoria_dados: self-checking bench for the data-memory arbiter (round-robin and fixed-priority instances)
module tb_arbitro_memoria_dados;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic req_a = 0, req_b = 0, esc_a = 0, esc_b = 0;
  logic [7:0] end_a = 0, end_b = 0, dado_a = 0, dado_b = 0;
  logic ack_a, ack_b, ocupado, we, re;
  logic [7:0] leitura_a, leitura_b, maddr, mdin, mdout;
  logic p_req_a = 0, p_req_b = 0, p_esc_a = 0, p_esc_b = 0;
  logic [7:0] p_end_a = 0, p_end_b = 0, p_dado_a = 0, p_dado_b = 0;
  logic p_ack_a, p_ack_b, p_ocupado, p_we, p_re;
  logic [7:0] p_leitura_a, p_leitura_b, p_maddr, p_mdin, p_mdout;
  int errors = 0;
  int checks = 0;
  logic [7:0] ref_mem[256];
  arbitro_memoria_dados #(.PRIORIDADE_A(0)) dut (
    .clk(clk), .reset(reset), .req_a(req_a), .req_b(req_b), .esc_a(esc_a), .esc_b(esc_b),
    .end_a(end_a), .end_b(end_b), .dado_a(dado_a), .dado_b(dado_b), .ack_a(ack_a), .ack_b(ack_b),
    .leitura_a(leitura_a), .leitura_b(leitura_b), .ocupado(ocupado), .mem_habilita_escrita(we),
    .mem_habilita_leitura(re), .mem_endereco(maddr), .mem_dado_entrada(mdin), .mem_dado_saida(mdout)
  );
  arbitro_memoria_dados #(.PRIORIDADE_A(1), .MAX_ESPERA(4)) dut_p (
    .clk(clk), .reset(reset), .req_a(p_req_a), .req_b(p_req_b), .esc_a(p_esc_a), .esc_b(p_esc_b),
    .end_a(p_end_a), .end_b(p_end_b), .dado_a(p_dado_a), .dado_b(p_dado_b), .ack_a(p_ack_a), .ack_b(p_ack_b),
    .leitura_a(p_leitura_a), .leitura_b(p_leitura_b), .ocupado(p_ocupado), .mem_habilita_escrita(p_we),
    .mem_habilita_leitura(p_re), .mem_endereco(p_maddr), .mem_dado_entrada(p_mdin), .mem_dado_saida(p_mdout)
  );
  function automatic logic [7:0] preload(input logic [7:0] a);
    return (a == 8'h20) ? 8'h00 : 8'(a * 37 + 11);
  endfunction
  logic [7:0] mem0[256];
  logic vld0[256] = '{default: 1'b0};
  logic [7:0] mem1[256];
  logic vld1[256] = '{default: 1'b0};
  always @(posedge clk) if (we) begin mem0[maddr] <= mdin; vld0[maddr] <= 1'b1; end
  always @(posedge clk) if (p_we) begin mem1[p_maddr] <= p_mdin; vld1[p_maddr] <= 1'b1; end
  function automatic logic [7:0] rd0(input logic [7:0] a);
    return vld0[a] ? mem0[a] : preload(a);
  endfunction
  assign mdout = rd0(maddr);
  assign p_mdout = vld1[p_maddr] ? mem1[p_maddr] : preload(p_maddr);
  always @(negedge clk) if (reset) begin
    checks++;
    if ((ack_a && ack_b) || (we && re) || (p_ack_a && p_ack_b) || (p_we && p_re)) begin
      errors++;
      $display("FAIL exclusive acks=%b%b en=%b%b p_acks=%b%b p_en=%b%b required at most one of each pair", ack_a, ack_b, we, re, p_ack_a, p_ack_b, p_we, p_re);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  task automatic drive(input int s, input logic r, input logic e, input logic [7:0] a, input logic [7:0] d);
    if (s == 0) begin req_a = r; esc_a = e; end_a = a; dado_a = d; end
    else begin req_b = r; esc_b = e; end_b = a; dado_b = d; end
  endtask
  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({ack_a, ack_b, leitura_a, leitura_b, ocupado, we, re, maddr, mdin} !== 37'd0) begin
      errors++;
      $display("FAIL reset_rr got ack=%b%b la=%h lb=%h oc=%b we=%b re=%b addr=%h din=%h required all 0", ack_a, ack_b, leitura_a, leitura_b, ocupado, we, re, maddr, mdin);
    end
    checks++;
    if ({p_ack_a, p_ack_b, p_leitura_a, p_leitura_b, p_ocupado, p_we, p_re, p_maddr, p_mdin} !== 37'd0) begin
      errors++;
      $display("FAIL reset_prio got ack=%b%b oc=%b we=%b re=%b addr=%h required all 0", p_ack_a, p_ack_b, p_ocupado, p_we, p_re, p_maddr);
    end
    @(negedge clk) reset = 1'b1;
  endtask
  task automatic test_write_read();
    drive(0, 1, 1, 8'h10, 8'hA5);
    @(negedge clk);
    checks++;
    if ({we, re, ocupado, maddr, mdin} !== {3'b101, 8'h10, 8'hA5}) begin
      errors++;
      $display("FAIL wr_pins got we=%b re=%b oc=%b addr=%h din=%h required 1 0 1 10 a5", we, re, ocupado, maddr, mdin);
    end
    drive(0, 1, 0, 8'hEE, 8'h00);
    @(negedge clk);
    checks++;
    if ({ack_a, we, rd0(8'h10)} !== {2'b10, 8'hA5}) begin
      errors++;
      $display("FAIL wr_ack got ack=%b we=%b mem10=%h required 1 0 a5", ack_a, we, rd0(8'h10));
    end
    ref_mem[8'h10] = 8'hA5;
    drive(0, 1, 0, 8'h10, 8'h00);
    @(negedge clk);
    checks++;
    if ({re, we, maddr} !== {2'b10, 8'h10}) begin
      errors++;
      $display("FAIL rd_pins got re=%b we=%b addr=%h required 1 0 10", re, we, maddr);
    end
    @(negedge clk);
    checks++;
    if ({ack_a, leitura_a} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL rd_ack got ack=%b data=%h required 1 a5", ack_a, leitura_a);
    end
    drive(0, 1, 1, 8'hFF, 8'h5E);
    @(negedge clk);
    checks++;
    if ({we, maddr, mdin} !== {1'b1, 8'hFF, 8'h5E}) begin
      errors++;
      $display("FAIL addr_ff got we=%b addr=%h din=%h required 1 ff 5e", we, maddr, mdin);
    end
    @(negedge clk);
    checks++;
    if ({ack_a, leitura_a, rd0(8'hFF)} !== {1'b1, 8'hA5, 8'h5E}) begin
      errors++;
      $display("FAIL ff_ack got ack=%b hold=%h memff=%h required 1 a5 5e", ack_a, leitura_a, rd0(8'hFF));
    end
    ref_mem[8'hFF] = 8'h5E;
    drive(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
  endtask
  task automatic test_rr_same_cycle();
    drive(0, 1, 0, 8'h20, 8'h00);
    drive(1, 1, 1, 8'h20, 8'h3C);
    @(negedge clk);
    checks++;
    if ({re, we, maddr} !== {2'b10, 8'h20}) begin
      errors++;
      $display("FAIL rr_first got re=%b we=%b addr=%h required 1 0 20", re, we, maddr);
    end
    @(negedge clk);
    checks++;
    if ({ack_a, ack_b, leitura_a, we, mdin} !== {2'b10, 8'h00, 1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL rr_second got ack=%b%b la=%h we=%b din=%h required 10 00 1 3c", ack_a, ack_b, leitura_a, we, mdin);
    end
    req_a = 0;
    @(negedge clk);
    checks++;
    if ({ack_a, ack_b} !== 2'b01) begin
      errors++;
      $display("FAIL rr_ack_b got ack=%b%b required 01", ack_a, ack_b);
    end
    ref_mem[8'h20] = 8'h3C;
    req_b = 0;
    drive(0, 1, 0, 8'h20, 8'h00);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ack_a, leitura_a} !== {1'b1, ref_mem[8'h20]}) begin
      errors++;
      $display("FAIL rr_reread got ack=%b data=%h required 1 %h", ack_a, leitura_a, ref_mem[8'h20]);
    end
    req_a = 0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid_service();
    drive(1, 1, 1, 8'h05, 8'h77);
    @(negedge clk);
    checks++;
    if ({we, maddr, mdin} !== {1'b1, 8'h05, 8'h77}) begin
      errors++;
      $display("FAIL rst_pre got we=%b addr=%h din=%h required 1 05 77", we, maddr, mdin);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ack_a, ack_b, leitura_a, leitura_b, ocupado, we, re, maddr, mdin} !== 37'd0) begin
      errors++;
      $display("FAIL rst_async got ack=%b%b la=%h oc=%b we=%b re=%b addr=%h required all 0", ack_a, ack_b, leitura_a, ocupado, we, re, maddr);
    end
    req_b = 0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ack_b, ocupado, rd0(8'h05)} !== {2'b00, ref_mem[8'h05]}) begin
      errors++;
      $display("FAIL rst_after got ack_b=%b oc=%b mem05=%h required 0 0 %h", ack_b, ocupado, rd0(8'h05), ref_mem[8'h05]);
    end
  endtask
  task automatic test_stream();
    int k = 0;
    drive(0, 1, 0, 8'h00, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack_a) begin
        checks++;
        if (c != 2 * (k + 1) || leitura_a !== ref_mem[8'(k)]) begin
          errors++;
          $display("FAIL stream got cycle=%0d data=%h required cycle=%0d data=%h", c, leitura_a, 2 * (k + 1), ref_mem[8'(k)]);
        end
        k++;
        if (k < 4) end_a = 8'(k);
        else req_a = 0;
      end
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL stream_count got %0d required 4", k);
    end
  endtask
  task automatic test_back_to_back();
    int ka = 0;
    int kb = 0;
    logic want_a, want_b;
    drive(0, 1, 0, 8'h30, 8'h00);
    drive(1, 1, 1, 8'h40, 8'h90);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      want_a = c >= 2 && c <= 7 && c % 2 == 0;
      want_b = c >= 3 && c <= 7 && c % 2 == 1;
      checks++;
      if (ack_a !== want_a || ack_b !== want_b) begin
        errors++;
        $display("FAIL b2b_acks cycle %0d got %b%b required %b%b", c, ack_a, ack_b, want_a, want_b);
      end
      if (ack_a) begin
        checks++;
        if (leitura_a !== ref_mem[8'(48 + ka)]) begin
          errors++;
          $display("FAIL b2b_read got %h required %h", leitura_a, ref_mem[8'(48 + ka)]);
        end
        ka++;
        if (ka < 3) end_a = 8'(48 + ka);
        else req_a = 0;
      end
      if (ack_b) begin
        ref_mem[8'(64 + kb)] = 8'(144 + kb);
        kb++;
        if (kb < 3) begin end_b = 8'(64 + kb); dado_b = 8'(144 + kb); end
        else req_b = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd0(8'(64 + i)) !== ref_mem[8'(64 + i)]) begin
        errors++;
        $display("FAIL b2b_mem addr %h got %h required %h", 8'(64 + i), rd0(8'(64 + i)), ref_mem[8'(64 + i)]);
      end
    end
  endtask
  task automatic test_rr_pointer();
    drive(0, 1, 0, 8'h70, 8'h00);
    drive(1, 1, 0, 8'h71, 8'h00);
    @(negedge clk);
    checks++;
    if ({re, maddr} !== {1'b1, 8'h71}) begin
      errors++;
      $display("FAIL ptr_first got re=%b addr=%h required 1 71", re, maddr);
    end
    @(negedge clk);
    checks++;
    if ({ack_b, leitura_b, maddr} !== {1'b1, ref_mem[8'h71], 8'h70}) begin
      errors++;
      $display("FAIL ptr_b got ack=%b data=%h addr=%h required 1 %h 70", ack_b, leitura_b, maddr, ref_mem[8'h71]);
    end
    req_b = 0;
    @(negedge clk);
    checks++;
    if ({ack_a, leitura_a} !== {1'b1, ref_mem[8'h70]}) begin
      errors++;
      $display("FAIL ptr_a got ack=%b data=%h required 1 %h", ack_a, leitura_a, ref_mem[8'h70]);
    end
    req_a = 0;
    @(negedge clk);
  endtask
  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({ocupado, we, re, ack_a, ack_b, maddr} !== {5'b0, 8'h70}) begin
        errors++;
        $display("FAIL idle got oc=%b we=%b re=%b ack=%b%b addr=%h required 0 0 0 00 70", ocupado, we, re, ack_a, ack_b, maddr);
      end
    end
  endtask
  task automatic test_anti_starvation();
    logic win_b;
    for (int r = 0; r < 6; r++) begin
      win_b = r == 4;
      p_req_a = 1; p_esc_a = 0; p_end_a = 8'(80 + r);
      p_req_b = 1; p_esc_b = 0; p_end_b = 8'(96 + r);
      @(negedge clk);
      checks++;
      if ({p_re, p_maddr} !== {1'b1, win_b ? 8'(96 + r) : 8'(80 + r)}) begin
        errors++;
        $display("FAIL prio_grant round %0d got re=%b addr=%h required B=%b", r, p_re, p_maddr, win_b);
      end
      if (win_b) begin
        @(negedge clk);
        checks++;
        if ({p_ack_b, p_leitura_b, p_maddr} !== {1'b1, ref_mem[8'(96 + r)], 8'(80 + r)}) begin
          errors++;
          $display("FAIL prio_b got ack=%b data=%h addr=%h required 1 %h %h", p_ack_b, p_leitura_b, p_maddr, ref_mem[8'(96 + r)], 8'(80 + r));
        end
        p_req_b = 0;
      end else p_req_b = 0;
      @(negedge clk);
      checks++;
      if ({p_ack_a, p_ack_b, p_leitura_a} !== {2'b10, ref_mem[8'(80 + r)]}) begin
        errors++;
        $display("FAIL prio_a round %0d got ack=%b%b data=%h required 10 %h", r, p_ack_a, p_ack_b, p_leitura_a, ref_mem[8'(80 + r)]);
      end
      p_req_a = 0;
      @(negedge clk);
    end
  endtask
  task automatic test_random();
    logic pend[2];
    logic ce[2];
    int age[2];
    logic [7:0] ca[2], cd[2];
    logic [1:0] acks;
    logic [7:0] lt;
    for (int s = 0; s < 2; s++) begin pend[s] = 0; ce[s] = 0; age[s] = 0; ca[s] = 0; cd[s] = 0; end
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      acks = {ack_b, ack_a};
      for (int s = 0; s < 2; s++) begin
        lt = (s == 0) ? leitura_a : leitura_b;
        if (acks[s]) begin
          checks++;
          if (!pend[s]) begin
            errors++;
            $display("FAIL rnd_spurious side %0d got ack=1 required 0", s);
          end else if (ce[s]) begin
            ref_mem[ca[s]] = cd[s];
            if (rd0(ca[s]) !== cd[s]) begin
              errors++;
              $display("FAIL rnd_write side %0d addr %h got %h required %h", s, ca[s], rd0(ca[s]), cd[s]);
            end
          end else if (lt !== ref_mem[ca[s]]) begin
            errors++;
            $display("FAIL rnd_read side %0d addr %h got %h required %h", s, ca[s], lt, ref_mem[ca[s]]);
          end
          pend[s] = 0;
        end else if (pend[s]) begin
          age[s]++;
          if (age[s] > 6) begin
            checks++;
            errors++;
            $display("FAIL rnd_timeout side %0d got no ack in %0d cycles required ack", s, age[s]);
            pend[s] = 0;
          end
        end
        if (!pend[s] && c < 400 && $urandom_range(0, 2) == 0) begin
          pend[s] = 1;
          age[s] = 0;
          ce[s] = 1'($urandom_range(0, 1));
          ca[s] = 8'($urandom_range(0, 7));
          cd[s] = 8'($urandom);
        end
        drive(s, pend[s], ce[s], ca[s], cd[s]);
      end
    end
    checks++;
    if (pend[0] || pend[1]) begin
      errors++;
      $display("FAIL rnd_drain got pending=%b%b required 00", pend[0], pend[1]);
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = preload(8'(i));
    test_reset();
    test_write_read();
    test_rr_same_cycle();
    test_reset_mid_service();
    test_stream();
    test_back_to_back();
    test_rr_pointer();
    test_idle();
    test_anti_starvation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
